// File: rtl/spike_bus_arbiter_if.sv
// Signal bundle for spike_bus_arbiter: requester request/ack side plus the
// single-beat CPUNC AXI channels. "master" is the arbiter view, "slave" the environment view.
interface spike_bus_arbiter_if #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_ADDR_WIDTH = 12
);
  logic [NUM_MASTERS-1:0]                M_REQ;
  logic [NUM_MASTERS-1:0]                M_WE;
  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] M_ADDR;
  logic [NUM_MASTERS*2-1:0]              M_SIZE;
  logic [NUM_MASTERS*32-1:0]             M_WDATA;
  logic [NUM_MASTERS-1:0]                M_ACK;
  logic [31:0]                           M_RDATA;
  logic                                  M_ERR;
  logic [NUM_MASTERS-1:0]                GRANT;

  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR;
  logic                      CPUNC_AWVALID;
  logic                      CPUNC_AWREADY;
  logic [31:0]               CPUNC_WDATA;
  logic [3:0]                CPUNC_WSTRB;
  logic                      CPUNC_WLAST;
  logic                      CPUNC_WVALID;
  logic                      CPUNC_WREADY;
  logic                      CPUNC_BRESP;
  logic                      CPUNC_BVALID;
  logic                      CPUNC_BREADY;
  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR;
  logic                      CPUNC_ARVALID;
  logic                      CPUNC_ARREADY;
  logic [31:0]               CPUNC_RDATA;
  logic                      CPUNC_RRESP;
  logic                      CPUNC_RVALID;
  logic                      CPUNC_RREADY;

  modport master (
    input  M_REQ, M_WE, M_ADDR, M_SIZE, M_WDATA,
    output M_ACK, M_RDATA, M_ERR, GRANT,
    output CPUNC_AWADDR, CPUNC_AWVALID, CPUNC_WDATA, CPUNC_WSTRB, CPUNC_WLAST, CPUNC_WVALID,
    output CPUNC_BREADY, CPUNC_ARADDR, CPUNC_ARVALID, CPUNC_RREADY,
    input  CPUNC_AWREADY, CPUNC_WREADY, CPUNC_BRESP, CPUNC_BVALID,
    input  CPUNC_ARREADY, CPUNC_RDATA, CPUNC_RRESP, CPUNC_RVALID
  );

  modport slave (
    output M_REQ, M_WE, M_ADDR, M_SIZE, M_WDATA,
    input  M_ACK, M_RDATA, M_ERR, GRANT,
    input  CPUNC_AWADDR, CPUNC_AWVALID, CPUNC_WDATA, CPUNC_WSTRB, CPUNC_WLAST, CPUNC_WVALID,
    input  CPUNC_BREADY, CPUNC_ARADDR, CPUNC_ARVALID, CPUNC_RREADY,
    output CPUNC_AWREADY, CPUNC_WREADY, CPUNC_BRESP, CPUNC_BVALID,
    output CPUNC_ARREADY, CPUNC_RDATA, CPUNC_RRESP, CPUNC_RVALID
  );
endinterface

// File: rtl/spike_bus_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI master port among NUM_MASTERS
// request/ack clients, with byte-lane steering and alignment checking.
module spike_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32
) (
  input logic                 CPUNC_ACLK,
  input logic                 CPUNC_ARESET,
  spike_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int AW = AXI_ADDR_WIDTH;

  if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("spike_bus_arbiter: AXI_DATA_WIDTH must be 32");
  end
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("spike_bus_arbiter: NUM_MASTERS must be 2..8");
  end

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [31:0]            m_rdata_q, m_rdata_d;
  logic                   m_err_q, m_err_d;
  logic [AW-1:0]          awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]            axi_wdata_q, axi_wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;

  logic [AW-1:0] req_addr  [NUM_MASTERS];
  logic [1:0]    req_size  [NUM_MASTERS];
  logic [31:0]   req_wdata [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign req_addr[g]  = bus.M_ADDR[g*AW +: AW];
    assign req_size[g]  = bus.M_SIZE[g*2 +: 2];
    assign req_wdata[g] = bus.M_WDATA[g*32 +: 32];
  end

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = ~a[0];
      2'd2:    is_aligned = (a == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  // Lowest index above the pointer wins; otherwise wrap to the lowest index at or below it.
  logic          req_found;
  logic [IW-1:0] req_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    req_found = 1'b0;
    req_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.M_REQ[i] && IW'(i) <= rr_ptr_q) begin
        req_found = 1'b1;
        req_idx   = IW'(i);
      end
    end
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.M_REQ[i] && IW'(i) > rr_ptr_q) begin
        req_found = 1'b1;
        req_idx   = IW'(i);
      end
    end
  end

  logic [31:0] rd_shift;
  logic [3:0]  strb_base;
  assign rd_shift  = bus.CPUNC_RDATA >> {addr_q[1:0], 3'b000};
  assign strb_base = (size_q == 2'd0) ? 4'b0001 : (size_q == 2'd1) ? 4'b0011 : 4'b1111;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    m_rdata_d   = m_rdata_q;
    m_err_d     = m_err_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    axi_wdata_d = axi_wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      S_IDLE: if (req_found) begin
        owner_d  = req_idx;
        rr_ptr_d = req_idx;
        we_d     = bus.M_WE[req_idx];
        addr_d   = req_addr[req_idx];
        size_d   = req_size[req_idx];
        wdata_d  = req_wdata[req_idx];
        if (!is_aligned(req_size[req_idx], req_addr[req_idx][1:0])) begin
          state_d   = S_RESP;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else if (bus.M_WE[req_idx]) begin
          state_d  = S_AW;
          awaddr_d = {req_addr[req_idx][AW-1:2], 2'b00};
        end else begin
          state_d  = S_AR;
          araddr_d = {req_addr[req_idx][AW-1:2], 2'b00};
        end
      end
      S_AR: if (bus.CPUNC_ARREADY) state_d = S_R;
      S_R: if (bus.CPUNC_RVALID) begin
        state_d = S_RESP;
        m_err_d = bus.CPUNC_RRESP;
        case (size_q)
          2'd0:    m_rdata_d = {24'h0, rd_shift[7:0]};
          2'd1:    m_rdata_d = {16'h0, rd_shift[15:0]};
          default: m_rdata_d = bus.CPUNC_RDATA;
        endcase
      end
      S_AW: if (bus.CPUNC_AWREADY) begin
        state_d     = S_W;
        axi_wdata_d = wdata_q << {addr_q[1:0], 3'b000};
        wstrb_d     = strb_base << addr_q[1:0];
      end
      S_W: if (bus.CPUNC_WREADY) state_d = S_B;
      S_B: if (bus.CPUNC_BVALID) begin
        state_d   = S_RESP;
        m_err_d   = bus.CPUNC_BRESP;
        m_rdata_d = '0;
      end
      S_RESP: begin
        state_d   = S_IDLE;
        m_err_d   = 1'b0;
        m_rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    awvalid_d = (state_d == S_AW);
    wvalid_d  = (state_d == S_W);
    bready_d  = (state_d == S_B);
    grant_d   = (state_d == S_IDLE) ? '0 : (NUM_MASTERS'(1) << owner_d);
    ack_d     = (state_d == S_RESP) ? (NUM_MASTERS'(1) << owner_d) : '0;
  end

  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IW'(NUM_MASTERS - 1);
      owner_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      axi_wdata_q <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      m_rdata_q   <= m_rdata_d;
      m_err_q     <= m_err_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      axi_wdata_q <= axi_wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
    end
  end

  assign bus.M_ACK         = ack_q;
  assign bus.M_RDATA       = m_rdata_q;
  assign bus.M_ERR         = m_err_q;
  assign bus.GRANT         = grant_q;
  assign bus.CPUNC_AWADDR  = awaddr_q;
  assign bus.CPUNC_AWVALID = awvalid_q;
  assign bus.CPUNC_WDATA   = axi_wdata_q;
  assign bus.CPUNC_WSTRB   = wstrb_q;
  assign bus.CPUNC_WLAST   = wvalid_q;
  assign bus.CPUNC_WVALID  = wvalid_q;
  assign bus.CPUNC_BREADY  = bready_q;
  assign bus.CPUNC_ARADDR  = araddr_q;
  assign bus.CPUNC_ARVALID = arvalid_q;
  assign bus.CPUNC_RREADY  = rready_q;

  // The owner must keep its request up while its bus transaction is in flight.
  logic busy;
  assign busy = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW) ||
                (state_q == S_W) || (state_q == S_B);

  req_held_a: assert property (@(posedge CPUNC_ACLK) disable iff (CPUNC_ARESET)
                               busy |-> bus.M_REQ[owner_q]);
endmodule

// File: tb/tb_spike_bus_arbiter.sv
// Directed self-checking bench for spike_bus_arbiter with a configurable-stall AXI slave.
module tb_spike_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  spike_bus_arbiter_if #(.NUM_MASTERS(NM), .AXI_ADDR_WIDTH(AW)) bus ();

  spike_bus_arbiter #(.NUM_MASTERS(NM), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32)) dut (
    .CPUNC_ACLK  (clk),
    .CPUNC_ARESET(rst),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Slave: each READY/VALID response rises after 'stall' cycles of the opposing signal.
  int          stall = 0;
  int          w_stall = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        rresp_cfg = 1'b0;
  logic        bresp_cfg = 1'b0;
  int ar_c, aw_c, w_c, r_c, b_c;

  initial begin
    {bus.CPUNC_ARREADY, bus.CPUNC_AWREADY, bus.CPUNC_WREADY, bus.CPUNC_RVALID, bus.CPUNC_BVALID} = '0;
    bus.CPUNC_RDATA = '0; bus.CPUNC_RRESP = 1'b0; bus.CPUNC_BRESP = 1'b0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {bus.CPUNC_ARREADY, bus.CPUNC_AWREADY, bus.CPUNC_WREADY, bus.CPUNC_RVALID, bus.CPUNC_BVALID} = '0;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
      end else begin
        if (bus.CPUNC_ARVALID) begin bus.CPUNC_ARREADY = (ar_c >= stall); ar_c++; end
        else begin bus.CPUNC_ARREADY = 1'b0; ar_c = 0; end
        if (bus.CPUNC_AWVALID) begin bus.CPUNC_AWREADY = (aw_c >= stall); aw_c++; end
        else begin bus.CPUNC_AWREADY = 1'b0; aw_c = 0; end
        if (bus.CPUNC_WVALID) begin bus.CPUNC_WREADY = (w_c >= w_stall); w_c++; end
        else begin bus.CPUNC_WREADY = 1'b0; w_c = 0; end
        if (bus.CPUNC_RREADY) begin bus.CPUNC_RVALID = (r_c >= stall); r_c++; end
        else begin bus.CPUNC_RVALID = 1'b0; r_c = 0; end
        if (bus.CPUNC_BREADY) begin bus.CPUNC_BVALID = (b_c >= stall); b_c++; end
        else begin bus.CPUNC_BVALID = 1'b0; b_c = 0; end
        bus.CPUNC_RDATA = rdata_cfg;
        bus.CPUNC_RRESP = rresp_cfg;
        bus.CPUNC_BRESP = bresp_cfg;
      end
    end
  end

  // Monitor: samples just after the falling edge, once the slave has driven its side.
  int arv_cyc, awv_cyc, wv_cyc, rr_cyc, ar_hs, aw_hs, ack_cnt, ack_multi, w_early, unstable, wlast_bad, glog_n;
  logic          aw_done, prev_ack, prev_arv, prev_awv, prev_wv;
  logic [AW-1:0] prev_araddr, prev_awaddr, cap_araddr, cap_awaddr;
  logic [31:0]   prev_wdata, cap_wdata, cap_rdata;
  logic [3:0]    cap_wstrb;
  logic          cap_wlast, cap_err;
  logic [NM-1:0] cap_ack;
  logic [NM-1:0] glog [16];

  task automatic clear_mon();
    {arv_cyc, awv_cyc, wv_cyc, rr_cyc, ar_hs, aw_hs} = '0;
    {ack_cnt, ack_multi, w_early, unstable, wlast_bad, glog_n} = '0;
    {aw_done, prev_ack, prev_arv, prev_awv, prev_wv} = '0;
    cap_araddr = '0; cap_awaddr = '0; cap_wdata = '0; cap_rdata = '0;
    cap_wstrb = '0; cap_wlast = 1'b0; cap_err = 1'b0; cap_ack = '0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk); #1;
      if (bus.CPUNC_WLAST !== bus.CPUNC_WVALID) wlast_bad++;
      if (bus.CPUNC_ARVALID) begin
        arv_cyc++;
        if (prev_arv && bus.CPUNC_ARADDR !== prev_araddr) unstable++;
        if (bus.CPUNC_ARREADY) begin ar_hs++; cap_araddr = bus.CPUNC_ARADDR; end
      end
      if (bus.CPUNC_AWVALID) begin
        awv_cyc++;
        if (prev_awv && bus.CPUNC_AWADDR !== prev_awaddr) unstable++;
        if (bus.CPUNC_AWREADY) begin aw_hs++; cap_awaddr = bus.CPUNC_AWADDR; end
      end
      if (bus.CPUNC_WVALID) begin
        wv_cyc++;
        if (!aw_done) w_early++;
        if (prev_wv && bus.CPUNC_WDATA !== prev_wdata) unstable++;
        if (bus.CPUNC_WREADY) begin
          cap_wdata = bus.CPUNC_WDATA; cap_wstrb = bus.CPUNC_WSTRB; cap_wlast = bus.CPUNC_WLAST;
          aw_done = 1'b0;
        end
      end
      if (bus.CPUNC_AWVALID && bus.CPUNC_AWREADY) aw_done = 1'b1;
      if (bus.CPUNC_RREADY) rr_cyc++;
      if (|bus.M_ACK) begin
        ack_cnt++;
        if (prev_ack) ack_multi++;
        cap_ack = bus.M_ACK; cap_rdata = bus.M_RDATA; cap_err = bus.M_ERR;
        if (glog_n < 16) glog[glog_n] = bus.GRANT;
        glog_n++;
      end
      prev_ack = |bus.M_ACK;
      prev_arv = bus.CPUNC_ARVALID; prev_araddr = bus.CPUNC_ARADDR;
      prev_awv = bus.CPUNC_AWVALID; prev_awaddr = bus.CPUNC_AWADDR;
      prev_wv  = bus.CPUNC_WVALID;  prev_wdata  = bus.CPUNC_WDATA;
    end
  end

  task automatic set_fields(input logic m, input logic we, input logic [AW-1:0] addr,
                            input logic [1:0] size, input logic [31:0] wd);
    bus.M_WE[m] = we;
    if (m) begin bus.M_ADDR[AW +: AW] = addr; bus.M_SIZE[3:2] = size; bus.M_WDATA[63:32] = wd; end
    else   begin bus.M_ADDR[0 +: AW]  = addr; bus.M_SIZE[1:0] = size; bus.M_WDATA[31:0]  = wd; end
  endtask

  // One complete request: raise M_REQ, count falling edges until M_ACK, drop M_REQ.
  task automatic issue(input logic m, input logic we, input logic [AW-1:0] addr,
                       input logic [1:0] size, input logic [31:0] wd, output int waits);
    @(negedge clk); #2;
    clear_mon();
    set_fields(m, we, addr, size, wd);
    bus.M_REQ[m] = 1'b1;
    waits = 0;
    do begin @(negedge clk); #2; waits++; end while (!bus.M_ACK[m] && waits < 60);
    checks++;
    if (!bus.M_ACK[m]) begin failures++; $display("FAIL ack_timeout master=%0d waited=%0d", m, waits); end
    bus.M_REQ[m] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2; rst = 1'b1;
    @(negedge clk); #2; rst = 1'b0;
  endtask

  function automatic logic [127:0] all_outputs();
    return {bus.CPUNC_ARVALID, bus.CPUNC_AWVALID, bus.CPUNC_WVALID, bus.CPUNC_WLAST,
            bus.CPUNC_BREADY, bus.CPUNC_RREADY, bus.M_ERR, bus.M_ACK, bus.GRANT,
            bus.M_RDATA, bus.CPUNC_AWADDR, bus.CPUNC_ARADDR, bus.CPUNC_WDATA, bus.CPUNC_WSTRB};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (all_outputs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outputs()); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (all_outputs() !== '0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", all_outputs()); end
  endtask

  task automatic test_read();
    int waits;
    stall = 0; rdata_cfg = 32'hA1B2C3D4; rresp_cfg = 1'b0;
    issue(1'b0, 1'b0, 12'h103, 2'd0, 32'h0, waits);
    checks++; if (waits !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", waits); end
    checks++; if (cap_araddr !== 12'h100) begin failures++; $display("FAIL rd_araddr got=%h exp=100", cap_araddr); end
    checks++; if (arv_cyc !== 1 || ar_hs !== 1) begin failures++; $display("FAIL rd_arvalid_count got=%0d/%0d exp=1/1", arv_cyc, ar_hs); end
    checks++; if (cap_ack !== 2'b01 || ack_cnt !== 1 || ack_multi !== 0) begin
      failures++; $display("FAIL rd_ack got=%b cnt=%0d multi=%0d exp=01/1/0", cap_ack, ack_cnt, ack_multi); end
    checks++; if (cap_rdata !== 32'h000000A1 || cap_err !== 1'b0) begin
      failures++; $display("FAIL rd_byte_data got=%h err=%b exp=000000a1 err=0", cap_rdata, cap_err); end
    checks++; if (awv_cyc !== 0) begin failures++; $display("FAIL rd_no_aw got=%0d exp=0", awv_cyc); end

    issue(1'b1, 1'b0, 12'h002, 2'd1, 32'h0, waits);
    checks++; if (cap_rdata !== 32'h0000A1B2 || cap_ack !== 2'b10) begin
      failures++; $display("FAIL rd_half_data got=%h ack=%b exp=0000a1b2 ack=10", cap_rdata, cap_ack); end
    issue(1'b0, 1'b0, 12'h0FC, 2'd2, 32'h0, waits);
    checks++; if (cap_rdata !== 32'hA1B2C3D4 || cap_araddr !== 12'h0FC) begin
      failures++; $display("FAIL rd_word_data got=%h addr=%h exp=a1b2c3d4 addr=0fc", cap_rdata, cap_araddr); end
  endtask

  task automatic test_write();
    int waits;
    stall = 0; w_stall = 0; bresp_cfg = 1'b0;
    issue(1'b1, 1'b1, 12'h206, 2'd1, 32'h00001234, waits);
    checks++; if (waits !== 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", waits); end
    checks++; if (cap_awaddr !== 12'h204 || aw_hs !== 1) begin
      failures++; $display("FAIL wr_awaddr got=%h hs=%0d exp=204 hs=1", cap_awaddr, aw_hs); end
    checks++; if (cap_wdata !== 32'h12340000) begin failures++; $display("FAIL wr_wdata got=%h exp=12340000", cap_wdata); end
    checks++; if (cap_wstrb !== 4'b1100 || cap_wlast !== 1'b1) begin
      failures++; $display("FAIL wr_wstrb got=%b last=%b exp=1100 last=1", cap_wstrb, cap_wlast); end
    checks++; if (w_early !== 0 || wlast_bad !== 0) begin
      failures++; $display("FAIL wr_w_order early=%0d wlast_bad=%0d exp=0/0", w_early, wlast_bad); end
    checks++; if (cap_ack !== 2'b10 || cap_err !== 1'b0 || cap_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_ack got=%b err=%b rdata=%h exp=10/0/0", cap_ack, cap_err, cap_rdata); end
    checks++; if (arv_cyc !== 0) begin failures++; $display("FAIL wr_no_ar got=%0d exp=0", arv_cyc); end
    issue(1'b0, 1'b1, 12'h011, 2'd0, 32'h000000A5, waits);
    checks++; if (cap_wdata !== 32'h0000A500 || cap_wstrb !== 4'b0010 || cap_awaddr !== 12'h010) begin
      failures++; $display("FAIL wr_byte_lane got=%h/%b/%h exp=0000a500/0010/010", cap_wdata, cap_wstrb, cap_awaddr); end
  endtask

  task automatic test_back_to_back();
    logic [NM-1:0] exp_g [6];
    int cyc;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    stall = 0;
    pulse_reset();
    clear_mon();
    set_fields(1'b0, 1'b0, 12'h010, 2'd2, 32'h0);
    set_fields(1'b1, 1'b0, 12'h020, 2'd2, 32'h0);
    bus.M_REQ = 2'b11;
    cyc = 0;
    while (ack_cnt < 6 && cyc < 200) begin @(negedge clk); #2; cyc++; end
    bus.M_REQ = 2'b00;
    repeat (5) @(negedge clk);
    #2;
    checks++; if (ack_cnt !== 6) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=6", ack_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (glog[i] !== exp_g[i]) begin failures++; $display("FAIL b2b_grant_%0d got=%b exp=%b", i, glog[i], exp_g[i]); end
    end
  endtask

  task automatic test_misaligned();
    int waits;
    issue(1'b0, 1'b0, 12'h101, 2'd2, 32'h0, waits);
    checks++; if (waits !== 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", waits); end
    checks++; if (cap_ack !== 2'b01 || cap_err !== 1'b1) begin
      failures++; $display("FAIL mis_word_err got=%b err=%b exp=01 err=1", cap_ack, cap_err); end
    checks++; if (arv_cyc !== 0 || awv_cyc !== 0) begin
      failures++; $display("FAIL mis_no_bus ar=%0d aw=%0d exp=0/0", arv_cyc, awv_cyc); end
    issue(1'b1, 1'b1, 12'h000, 2'd3, 32'h0, waits);
    checks++; if (cap_err !== 1'b1 || awv_cyc !== 0 || waits !== 1) begin
      failures++; $display("FAIL mis_size3 err=%b aw=%0d waits=%0d exp=1/0/1", cap_err, awv_cyc, waits); end
    issue(1'b0, 1'b0, 12'h003, 2'd1, 32'h0, waits);
    checks++; if (cap_err !== 1'b1 || arv_cyc !== 0) begin
      failures++; $display("FAIL mis_half err=%b ar=%0d exp=1/0", cap_err, arv_cyc); end
  endtask

  task automatic test_stall_errors();
    int waits;
    stall = 3; w_stall = 3; rresp_cfg = 1'b1; bresp_cfg = 1'b1; rdata_cfg = 32'h55AA55AA;
    issue(1'b0, 1'b0, 12'h080, 2'd2, 32'h0, waits);
    checks++; if (waits !== 9) begin failures++; $display("FAIL stall_rd_latency got=%0d exp=9", waits); end
    checks++; if (arv_cyc !== 4 || rr_cyc !== 4 || unstable !== 0) begin
      failures++; $display("FAIL stall_rd_hold ar=%0d r=%0d unstable=%0d exp=4/4/0", arv_cyc, rr_cyc, unstable); end
    checks++; if (cap_err !== 1'b1) begin failures++; $display("FAIL stall_rresp got=%b exp=1", cap_err); end
    issue(1'b1, 1'b1, 12'h084, 2'd2, 32'hCAFEF00D, waits);
    checks++; if (waits !== 13) begin failures++; $display("FAIL stall_wr_latency got=%0d exp=13", waits); end
    checks++; if (awv_cyc !== 4 || wv_cyc !== 4 || unstable !== 0 || w_early !== 0) begin
      failures++; $display("FAIL stall_wr_hold aw=%0d w=%0d unstable=%0d early=%0d exp=4/4/0/0", awv_cyc, wv_cyc, unstable, w_early); end
    checks++; if (cap_err !== 1'b1 || cap_wdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL stall_bresp err=%b wdata=%h exp=1/cafef00d", cap_err, cap_wdata); end
    stall = 0; w_stall = 0; rresp_cfg = 1'b0; bresp_cfg = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    stall = 0; w_stall = 1000;
    @(negedge clk); #2;
    clear_mon();
    set_fields(1'b0, 1'b1, 12'h040, 2'd2, 32'hDEADBEEF);
    bus.M_REQ[0] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); #2; cyc++; end while (!bus.CPUNC_WVALID && cyc < 20);
    checks++; if (bus.CPUNC_WVALID !== 1'b1 || bus.CPUNC_WSTRB !== 4'b1111) begin
      failures++; $display("FAIL rm_reach_w wvalid=%b wstrb=%b exp=1/1111", bus.CPUNC_WVALID, bus.CPUNC_WSTRB); end
    #1 rst = 1'b1;
    #1;
    checks++; if (all_outputs() !== '0) begin failures++; $display("FAIL rm_async_clear got=%h exp=0", all_outputs()); end
    bus.M_REQ = 2'b00;
    @(negedge clk); #2;
    rst = 1'b0; w_stall = 0;
    clear_mon();
    set_fields(1'b0, 1'b0, 12'h000, 2'd2, 32'h0);
    set_fields(1'b1, 1'b0, 12'h004, 2'd2, 32'h0);
    bus.M_REQ = 2'b11;
    cyc = 0;
    while (ack_cnt < 1 && cyc < 40) begin @(negedge clk); #2; cyc++; end
    bus.M_REQ[0] = 1'b0;
    checks++; if (ack_cnt !== 1 || cap_ack !== 2'b01) begin
      failures++; $display("FAIL rm_priority cnt=%0d ack=%b exp=1/01", ack_cnt, cap_ack); end
    cyc = 0;
    while (ack_cnt < 2 && cyc < 40) begin @(negedge clk); #2; cyc++; end
    bus.M_REQ[1] = 1'b0;
    checks++; if (ack_cnt !== 2 || cap_ack !== 2'b10) begin
      failures++; $display("FAIL rm_second cnt=%0d ack=%b exp=2/10", ack_cnt, cap_ack); end
  endtask

  initial begin
    bus.M_REQ = '0; bus.M_WE = '0; bus.M_ADDR = '0; bus.M_SIZE = '0; bus.M_WDATA = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_misaligned();
    test_stall_errors();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
